// File: rtl/weight_chain_feeder.sv
// Buffers incoming weight words and streams whole vectors into the cell
// chain head, throttled by the number of vectors still awaiting results.
module weight_chain_feeder #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int MAX_INFLIGHT  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH-1:0]                 s_value,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [DATA_WIDTH-1:0]                 out_index,
  output logic [DATA_WIDTH-1:0]                 out_value,
  output logic [DATA_WIDTH:0]                   out_result,
  output logic                                  out_enable,
  input  logic [DATA_WIDTH:0]                   tail_result,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic                                  busy,
  output logic                                  err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WA_C    = CW'(WEIGHT_AMOUNT);
  localparam logic [KW-1:0] LAST_C  = KW'(WEIGHT_AMOUNT - 1);
  localparam logic [IW-1:0] MAX_C   = IW'(MAX_INFLIGHT);
  localparam logic [PW-1:0] PTR_TOP = PW'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [KW-1:0]         idx;
  logic [IW-1:0]         inflight_nxt;
  logic                  push;
  logic                  pop;
  logic                  last;
  logic                  rdone;
  logic                  start_now;
  logic                  start_nxt;
  logic                  tail_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_TOP) ? '0 : p + PW'(1);
  endfunction

  assign s_ready     = !rst && (count != DEPTH_C);
  assign push        = s_valid && s_ready;
  assign pop         = (state == STREAM);
  assign last        = pop && (idx == LAST_C);
  assign rdone       = tail_result[DATA_WIDTH];
  assign tail_unused = ^tail_result[DATA_WIDTH-1:0];
  assign out_result  = '0;
  assign count_nxt   = count + CW'(push) - CW'(pop);

  always_comb begin
    inflight_nxt = inflight;
    if (last && !rdone)
      inflight_nxt = inflight + IW'(1);
    else if (!last && rdone && inflight != '0)
      inflight_nxt = inflight - IW'(1);
  end

  // Start is judged on whole-vector availability so no bubbles occur
  assign start_now = (count >= WA_C) && (inflight < MAX_C);
  assign start_nxt = (count_nxt >= WA_C) && (inflight_nxt < MAX_C);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      inflight   <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      out_enable <= 1'b0;
      out_index  <= '0;
      out_value  <= '0;
    end else begin
      count    <= count_nxt;
      inflight <= inflight_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (rdone && inflight == '0) err <= 1'b1;
      unique case (state)
        IDLE: begin
          out_enable <= 1'b0;
          out_index  <= '0;
          out_value  <= '0;
          if (start_now) begin
            state <= STREAM;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        STREAM: begin
          out_enable <= 1'b1;
          out_index  <= DATA_WIDTH'(idx);
          out_value  <= mem[rd_ptr];
          if (last) begin
            idx <= '0;
            if (!start_nxt) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            idx <= idx + KW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/weight_chain_feeder.md
WEIGHT_CHAIN_FEEDER -- requirements
Module: weight_chain_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of index and value words.
REQ-002 Parameter WEIGHT_AMOUNT, default 4, sets the number of elements per input vector (index range 0..WEIGHT_AMOUNT-1).
REQ-003 Parameter FIFO_DEPTH, default 8, sets the input word buffer depth; FIFO_DEPTH SHALL be >= WEIGHT_AMOUNT.
REQ-004 Parameter MAX_INFLIGHT, default 4, sets the maximum number of vectors streamed whose results have not yet returned.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 s_value  input  DATA_WIDTH  incoming vector element, in index order.
REQ-008 s_valid  input  1  s_value is valid.
REQ-009 s_ready  output  1  feeder accepts s_value this cycle.
REQ-010 out_index  output  DATA_WIDTH  element index driven to the head of the cell chain.
REQ-011 out_value  output  DATA_WIDTH  element value driven to the chain head.
REQ-012 out_result  output  DATA_WIDTH+1  result-chain input at the chain head; bit DATA_WIDTH is the valid flag.
REQ-013 out_enable  output  1  out_index/out_value valid.
REQ-014 tail_result  input  DATA_WIDTH+1  result word from the chain tail; bit DATA_WIDTH is the valid flag.
REQ-015 inflight  output  clog2(MAX_INFLIGHT+1)  number of vectors streamed and awaiting results.
REQ-016 busy  output  1  high while in state STREAM.
REQ-017 err  output  1  sticky flag: result received with inflight == 0.

Function
REQ-018 A word SHALL be accepted on a cycle with s_valid && s_ready and written to the FIFO tail.
REQ-019 s_ready SHALL equal (FIFO not full) and SHALL not depend on a same-cycle pop.
REQ-020 States: IDLE and STREAM.
REQ-021 IDLE -> STREAM when FIFO occupancy >= WEIGHT_AMOUNT and inflight < MAX_INFLIGHT; the index counter loads 0.
REQ-022 In STREAM, each cycle pops one word and registers out_enable=1, out_index=counter, out_value=popped word; the counter increments.
REQ-023 A vector SHALL be emitted as WEIGHT_AMOUNT consecutive cycles with no bubbles.
REQ-024 On the cycle the word with index WEIGHT_AMOUNT-1 is emitted, inflight increments.
REQ-025 After index WEIGHT_AMOUNT-1 the state stays in STREAM with counter 0 if the start condition in REQ-021 holds, evaluated with post-update occupancy and inflight; otherwise it returns to IDLE.
REQ-026 The occupancy check is made only at vector start; the words of a started vector SHALL already be present in the FIFO.
REQ-027 When out_enable is 0, out_index and out_value SHALL be 0.
REQ-028 out_result SHALL always be 0, because the chain head injects no result.
REQ-029 tail_result[DATA_WIDTH]=1 decrements inflight; increment and decrement in the same cycle leave inflight unchanged.
REQ-030 A tail result with inflight == 0 SHALL leave inflight at 0 and set err.
REQ-031 Latency: first out_enable is asserted 2 cycles after acceptance of the WEIGHT_AMOUNT-th word when IDLE and inflight < MAX_INFLIGHT.
REQ-032 FIFO pointers wrap modulo FIFO_DEPTH; simultaneous push and pop keep occupancy unchanged.
REQ-033 All outputs except s_ready SHALL be registered.

Reset
REQ-034 rst asserted SHALL force, asynchronously, the following: state IDLE, FIFO empty, counter 0, inflight 0, err 0, busy 0, out_enable 0, out_index 0, out_value 0, out_result 0.
REQ-035 s_ready SHALL be 0 while rst is high.
REQ-036 rst mid-vector aborts the vector; no further words of it are emitted, and buffered words are discarded.
REQ-037 After rst deasserts, out_enable SHALL remain 0 until a full vector is buffered.

Verification
REQ-038 WEIGHT_AMOUNT=4: push 5,6,7,8 back-to-back -> out_enable high for 4 cycles starting 2 cycles after the 8 is accepted; index 0..3 carries values 5..8; inflight becomes 1.
REQ-039 Push 8 words continuously -> two vectors back-to-back with zero idle cycles between index 3 and index 0; inflight becomes 2.
REQ-040 MAX_INFLIGHT=1, 8 words buffered, no tail result -> one vector, then IDLE with busy 0; a tail_result with bit 32 set -> second vector starts and inflight returns to 1.
REQ-041 Fill FIFO_DEPTH=8 with streaming blocked -> s_ready 0; the 9th s_valid word is not accepted; inflight reaches MAX_INFLIGHT.
REQ-042 Assert rst after index 1 is emitted -> out_enable 0 immediately; inflight 0 and FIFO empty; the next 4 pushes produce a clean vector with index 0..3.
REQ-043 tail_result valid with inflight 0 -> err 1 and held until rst; inflight stays 0.
